bpred_resolve_unit: RTL
=======================

Name: bpred_resolve_unit

Overview:
- Execute-side counterpart of the branch predictor's update port.
- Queues each prediction fetch issues (direction, target, bimodal counter state) in program order.
- Matches each entry against the in-order branch outcome from the ALU.
- Generates the execute_bpredictor_* update packet plus a fetch redirect on misprediction, squashing younger in-flight predictions.

Parameters:
- DEPTH, 4: prediction queue entries (power of 2, ≥2).
- BIMODAL_W, 12: width of the bimodal state carried with each prediction.
- RECOVER_CYC, 2: cycles after a miss during which fetch pushes are dropped (wrong-path drain).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_push  in  1  fetch issued a predicted branch this cycle.
- fetch_PC4  in  32  PC+4 of the branch.
- fetch_p_dir  in  1  predicted direction (1 = taken).
- fetch_p_target  in  32  predicted target.
- fetch_bimodal  in  BIMODAL_W  predictor state returned at fetch.
- bpred_full  out  1  queue full; fetch must stall.
- resolve_valid  in  1  ALU resolved the oldest outstanding branch.
- resolve_dir  in  1  actual direction.
- resolve_target  in  32  actual taken target.
- execute_bpredictor_update  out  1  one-cycle update strobe.
- execute_bpredictor_PC4  out  32
- execute_bpredictor_target  out  32
- execute_bpredictor_dir  out  1
- execute_bpredictor_miss  out  1
- execute_bpredictor_bimodal  out  BIMODAL_W
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  32  resolve_dir ? resolve_target : PC4.
- err_underflow  out  1  sticky: resolve_valid seen with empty queue.

Behaviour:
- Reset (reset=0, async):
  - Queue empty; state RUN.
  - All outputs 0; bpred_full=0; err_underflow=0.
- Queue:
  - Circular buffer; head/tail pointers are log2(DEPTH)+1 bits.
  - full when pointers differ only in the MSB; empty when equal.
  - Pointers wrap modulo 2·DEPTH.
- Push:
  - Accepted when fetch_push=1, state=RUN, and not full.
  - Push while full: dropped, no state change.
  - Push in RECOVER: dropped.
- Resolve when queue non-empty and resolve_valid=1:
  - Pop head.
  - miss = (p_dir≠resolve_dir) | (resolve_dir & p_target≠resolve_target).
  - Outputs registered; valid on the cycle after resolve_valid (latency 1).
  - update=1 for exactly one cycle; PC4, bimodal from the entry; dir=resolve_dir; target=resolve_target; miss as computed.
- Resolve with empty queue: ignored; err_underflow set until reset.
- Simultaneous push and resolve, no miss: both take effect; occupancy unchanged.
  - Push to a full queue in the same cycle as a pop is accepted.
- Miss:
  - Queue flushed (head=tail) at the same edge the outputs register.
  - Any same-cycle push is discarded.
  - redirect_valid=1 for one cycle with redirect_pc.
  - State goes to RECOVER with counter=RECOVER_CYC.
- RECOVER:
  - Counter decrements each cycle; at 0, state goes to RUN.
  - resolve_valid in RECOVER is treated as an empty-queue resolve.
- Strobes: update and redirect_valid return to 0 the following cycle unless another resolve occurs.
- Reset mid-operation: queue, state, counters and outputs cleared immediately.

Optional Feature:
- Macro: BPRED_RESOLVE_STATS_EN.
- Enabled:
  - Adds 32-bit outputs stat_branches and stat_misses.
  - Increment on each non-underflow resolve and each miss respectively.
  - Saturate at 32'hFFFF_FFFF; cleared by reset.
- Disabled: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Push PC4=128, p_dir=1, p_target=0, bimodal=12'h003; next cycle resolve dir=1, target=0 → one cycle later update=1, PC4=128, miss=0, bimodal=12'h003, redirect_valid=0.
- Push PC4=64, p_dir=0; resolve dir=1, target=32'h40 → miss=1, redirect_valid=1, redirect_pc=32'h40, queue empty.
  - Pushes in the next 2 cycles dropped; push on the 3rd cycle accepted.
- Push 4 entries (DEPTH=4) → bpred_full=1; 5th push dropped; resolve 4 times in order → PC4 outputs match push order, then a 5th resolve sets err_underflow=1.
- Full queue with simultaneous push and correct resolve → entry accepted, bpred_full stays 1, FIFO order preserved across pointer wrap.
- Pull reset low while 3 entries are queued and in RECOVER → all outputs 0 and queue empty immediately; after release, a push/resolve pair works.
- With BPRED_RESOLVE_STATS_EN: 3 correct and 2 mispredicted resolves → stat_branches=5, stat_misses=2.

Source files
------------

// File: rtl/bpred_resolve_unit.sv
// bpred_resolve_unit: queues fetch predictions in order, resolves them against ALU outcomes, emits update/redirect.
// Optional BPRED_RESOLVE_STATS_EN adds saturating stat_branches/stat_misses counters.
module bpred_resolve_unit #(
   parameter int DEPTH       = 4,
   parameter int BIMODAL_W   = 12,
   parameter int RECOVER_CYC = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fetch_push,
   input  logic [31:0]          fetch_PC4,
   input  logic                 fetch_p_dir,
   input  logic [31:0]          fetch_p_target,
   input  logic [BIMODAL_W-1:0] fetch_bimodal,
   output logic                 bpred_full,
   input  logic                 resolve_valid,
   input  logic                 resolve_dir,
   input  logic [31:0]          resolve_target,
   output logic                 execute_bpredictor_update,
   output logic [31:0]          execute_bpredictor_PC4,
   output logic [31:0]          execute_bpredictor_target,
   output logic                 execute_bpredictor_dir,
   output logic                 execute_bpredictor_miss,
   output logic [BIMODAL_W-1:0] execute_bpredictor_bimodal,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   output logic                 err_underflow
`ifdef BPRED_RESOLVE_STATS_EN
   ,
   output logic [31:0]          stat_branches,
   output logic [31:0]          stat_misses
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(RECOVER_CYC + 1) + 1;
   typedef enum logic {RUN, RECOVER} state_e;
   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW:0] head_q, head_d, tail_q, tail_d;
   logic [31:0] pc4_mem [DEPTH];
   logic [31:0] tgt_mem [DEPTH];
   logic [BIMODAL_W-1:0] bim_mem [DEPTH];
   logic [DEPTH-1:0] dir_mem;
   logic [AW-1:0] hd;
   logic empty, run, pop, miss, push;
   logic upd_q, dir_q, miss_q, redir_q, err_q;
   logic [31:0] pc4_q, tgt_q, rpc_q;
   logic [BIMODAL_W-1:0] bim_q;
   assign hd = head_q[AW-1:0];
   assign empty = head_q == tail_q;
   assign bpred_full = (head_q ^ tail_q) == {1'b1, {AW{1'b0}}};
   assign run = state_q == RUN;
   assign pop = resolve_valid & run & ~empty;
   assign miss = pop & ((dir_mem[hd] != resolve_dir) | (resolve_dir & (tgt_mem[hd] != resolve_target)));
   // a pop frees a slot in the same cycle, so a full queue still accepts the push
   assign push = fetch_push & run & (~bpred_full | pop) & ~miss;
   always_comb begin
      head_d = miss ? tail_q : head_q + (AW+1)'(pop);
      tail_d = tail_q + (AW+1)'(push);
      state_d = state_q;
      cnt_d = cnt_q;
      if (miss) begin
         state_d = (RECOVER_CYC == 0) ? RUN : RECOVER;
         cnt_d = CW'(RECOVER_CYC);
      end else if (!run) begin
         state_d = (cnt_q <= CW'(1)) ? RUN : RECOVER;
         cnt_d = cnt_q - CW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         pc4_mem[tail_q[AW-1:0]] <= fetch_PC4;
         tgt_mem[tail_q[AW-1:0]] <= fetch_p_target;
         bim_mem[tail_q[AW-1:0]] <= fetch_bimodal;
         dir_mem[tail_q[AW-1:0]] <= fetch_p_dir;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         upd_q <= 1'b0;
         dir_q <= 1'b0;
         miss_q <= 1'b0;
         redir_q <= 1'b0;
         err_q <= 1'b0;
         pc4_q <= '0;
         tgt_q <= '0;
         rpc_q <= '0;
         bim_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         upd_q <= pop;
         redir_q <= miss;
         err_q <= err_q | (resolve_valid & ~pop);
         if (pop) begin
            pc4_q <= pc4_mem[hd];
            bim_q <= bim_mem[hd];
            tgt_q <= resolve_target;
            dir_q <= resolve_dir;
            miss_q <= miss;
         end
         if (miss) rpc_q <= resolve_dir ? resolve_target : pc4_mem[hd];
      end
   end
   assign execute_bpredictor_update = upd_q;
   assign execute_bpredictor_PC4 = pc4_q;
   assign execute_bpredictor_target = tgt_q;
   assign execute_bpredictor_dir = dir_q;
   assign execute_bpredictor_miss = miss_q;
   assign execute_bpredictor_bimodal = bim_q;
   assign redirect_valid = redir_q;
   assign redirect_pc = rpc_q;
   assign err_underflow = err_q;
`ifdef BPRED_RESOLVE_STATS_EN
   logic [31:0] br_q, ms_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         br_q <= '0;
         ms_q <= '0;
      end else begin
         if (pop && !(&br_q)) br_q <= br_q + 32'd1;
         if (miss && !(&ms_q)) ms_q <= ms_q + 32'd1;
      end
   end
   assign stat_branches = br_q;
   assign stat_misses = ms_q;
`endif
endmodule
